// File: rtl/mmm_mult_pipe_if.sv
// Operand/result bundle for the pipelined multiply-accumulate unit.
// The master drives operands and pipeline controls; the slave (the multiplier) returns results.
interface mmm_mult_pipe_if #(
   parameter int unsigned IDW = 90,
   parameter int unsigned ODW = 2 * IDW + 1
);
   logic           i_valid;
   logic           i_stall;
   logic           i_flush;
   logic [IDW-1:0] i_a;
   logic [IDW-1:0] i_b;
   logic [IDW-1:0] i_c;
   logic           i_acc_en;
   logic           i_carry;
   logic           o_valid;
   logic [ODW-1:0] o_res;
   logic           o_busy;

   modport master (
      output i_valid, i_stall, i_flush, i_a, i_b, i_c, i_acc_en, i_carry,
      input  o_valid, o_res, o_busy
   );

   modport slave (
      input  i_valid, i_stall, i_flush, i_a, i_b, i_c, i_acc_en, i_carry,
      output o_valid, o_res, o_busy
   );
endinterface

// File: rtl/mmm_mult_pipe.sv
// Five-stage tiled multiplier: res = a*b + (acc_en ? c : 0) + carry.
// Stage 1 tile products, stage 2 aligned partial sums, stages 3-4 adder tree,
// stage 5 final sum with addend and carry (stage 5 is the o_res register).
module mmm_mult_pipe #(
   parameter int unsigned IDW = 90,
   parameter int unsigned TAW = 24,
   parameter int unsigned TBW = 16,
   parameter int unsigned ODW = 2 * IDW + 1
) (
   input logic            i_clk,
   input logic            i_rstn,
   mmm_mult_pipe_if.slave bus
);
   localparam int NA = int'((IDW + TAW - 1) / TAW);
   localparam int NB = int'((IDW + TBW - 1) / TBW);
   localparam int NP = NA * NB;
   localparam int AW = NA * int'(TAW);
   localparam int BW = NB * int'(TBW);
   localparam int PW = int'(TAW + TBW);
   // Partial sums are split into NG interleaved groups for the two tree levels.
   localparam int NG = 4;

   typedef struct packed {
      logic [IDW-1:0] c;
      logic           acc;
      logic           cy;
   } side_t;

   logic [4:0]     valid_q;
   side_t          side_q   [4];
   logic [AW-1:0]  a_pad;
   logic [BW-1:0]  b_pad;
   logic [PW-1:0]  prod_d   [NP];
   logic [PW-1:0]  prod_q   [NP];
   logic [ODW-1:0] psum_d   [NP];
   logic [ODW-1:0] psum_q   [NP];
   logic [ODW-1:0] grp_d    [NG];
   logic [ODW-1:0] grp_q    [NG];
   logic [ODW-1:0] sum4_d;
   logic [ODW-1:0] sum4_q;
   logic [ODW-1:0] res_d;
   logic [ODW-1:0] res_q;
   logic           hold;

   assign hold  = bus.i_stall;
   assign a_pad = AW'(bus.i_a);
   assign b_pad = BW'(bus.i_b);

   // Stage-1 input: every tile pair multiplied; top tiles are zero-extended by the padding.
   always_comb begin
      for (int k = 0; k < NP; k++) prod_d[k] = '0;
      for (int i = 0; i < NA; i++) begin
         for (int j = 0; j < NB; j++) begin
            prod_d[i*NB+j] = PW'(a_pad[i*TAW +: TAW]) * PW'(b_pad[j*TBW +: TBW]);
         end
      end
   end

   // Stage-2 input: shift each tile product to its weight in the full-width result.
   always_comb begin
      for (int k = 0; k < NP; k++) psum_d[k] = '0;
      for (int i = 0; i < NA; i++) begin
         for (int j = 0; j < NB; j++) begin
            psum_d[i*NB+j] = ODW'(prod_q[i*NB+j]) << (i * int'(TAW) + j * int'(TBW));
         end
      end
   end

   // Stage-3 input: first tree level, partial sum k goes to group k mod NG.
   always_comb begin
      for (int g = 0; g < NG; g++) begin
         grp_d[g] = '0;
         for (int k = 0; k < NP; k++) begin
            if (k % NG == g) grp_d[g] = grp_d[g] + psum_q[k];
         end
      end
   end

   // Stage-4 input: second tree level; stage-5 input adds the addend and carry.
   always_comb begin
      sum4_d = '0;
      for (int g = 0; g < NG; g++) sum4_d = sum4_d + grp_q[g];
      res_d = sum4_q + (side_q[3].acc ? ODW'(side_q[3].c) : ODW'(0)) + ODW'(side_q[3].cy);
   end

   // Valid bits: flush beats stall, stall freezes, otherwise shift in the accept.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         valid_q <= '0;
      end else if (bus.i_flush) begin
         valid_q <= '0;
      end else if (!hold) begin
         valid_q <= {valid_q[3:0], bus.i_valid};
      end
   end

   // Data registers of stages 1-4 and the sideband carried alongside them.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int k = 0; k < NP; k++) begin
            prod_q[k] <= '0;
            psum_q[k] <= '0;
         end
         for (int g = 0; g < NG; g++) grp_q[g] <= '0;
         for (int s = 0; s < 4; s++) side_q[s] <= '0;
         sum4_q <= '0;
      end else if (!hold) begin
         prod_q    <= prod_d;
         psum_q    <= psum_d;
         grp_q     <= grp_d;
         sum4_q    <= sum4_d;
         side_q[0] <= '{c: bus.i_c, acc: bus.i_acc_en, cy: bus.i_carry};
         for (int s = 1; s < 4; s++) side_q[s] <= side_q[s-1];
      end
   end

   // Result register: loads only when a valid op leaves stage 4; flush leaves it untouched.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         res_q <= '0;
      end else if (valid_q[3] && !hold && !bus.i_flush) begin
         res_q <= res_d;
      end
   end

   assign bus.o_valid = valid_q[4];
   assign bus.o_res   = res_q;
   assign bus.o_busy  = |valid_q;
endmodule
